// File: rtl/store_queue_if.sv
// rtl/store_queue_if.sv - LSU-side enqueue/commit/drain/forward bundle of the store queue
interface store_queue_if #(
    parameter int DEPTH    = 8,
    parameter int COMMIT_W = 2,
    parameter int ID_W     = 6
);
    localparam int PW = $clog2(DEPTH) + 1;

    logic                enq_valid;
    logic                enq_ready;
    logic [ID_W-1:0]     enq_id;
    logic [31:0]         enq_addr;
    logic [1:0]          enq_size;
    logic [31:0]         enq_data;
    logic                enq_cache;
    logic [COMMIT_W-1:0] com;
    logic                flush;
    logic                drn_valid;
    logic                drn_ready;
    logic [31:0]         drn_addr;
    logic [3:0]          drn_strb;
    logic [31:0]         drn_data;
    logic                drn_cache;
    logic [ID_W-1:0]     drn_id;
    logic [31:0]         ld_addr;
    logic [3:0]          ld_strb;
    logic [3:0]          fwd_mask;
    logic [31:0]         fwd_data;
    logic                fwd_stall;
    logic [PW-1:0]       count;
    logic                half;
    logic                empty;

    modport master (
        output enq_valid, enq_id, enq_addr, enq_size, enq_data, enq_cache,
        output com, flush, drn_ready, ld_addr, ld_strb,
        input  enq_ready, drn_valid, drn_addr, drn_strb, drn_data, drn_cache, drn_id,
        input  fwd_mask, fwd_data, fwd_stall, count, half, empty
    );

    modport slave (
        input  enq_valid, enq_id, enq_addr, enq_size, enq_data, enq_cache,
        input  com, flush, drn_ready, ld_addr, ld_strb,
        output enq_ready, drn_valid, drn_addr, drn_strb, drn_data, drn_cache, drn_id,
        output fwd_mask, fwd_data, fwd_stall, count, half, empty
    );
endinterface

// File: rtl/store_queue.sv
// rtl/store_queue.sv - in-order store queue with ROB commit, flush, drain and store-to-load forwarding
module store_queue #(
    parameter int DEPTH    = 8,
    parameter int COMMIT_W = 2,
    parameter int ID_W     = 6
) (
    input  logic          clk,
    input  logic          resetn,
    store_queue_if.slave  sq
);
    localparam int IW = $clog2(DEPTH);
    localparam int PW = IW + 1;

    logic [PW-1:0]   head_q, head_d, cptr_q, cptr_d, tail_q, tail_d;

    logic [ID_W-1:0] ent_id_q    [DEPTH];
    logic [29:0]     ent_addr_q  [DEPTH];
    logic [3:0]      ent_strb_q  [DEPTH];
    logic [31:0]     ent_data_q  [DEPTH];
    logic            ent_cache_q [DEPTH];

    logic [PW-1:0]   count_w, uncom_w, pop_w, commit_n_w;
    logic            full_w, enq_fire_w, drn_fire_w;
    logic [3:0]      enq_strb_w;
    logic [31:0]     enq_lane_w;
    logic [IW-1:0]   head_idx_w, fwd_idx_w;
    logic [3:0]      fwd_mask_w;
    logic [31:0]     fwd_data_w;
    logic            fwd_hit_w, fwd_unc_w;

    assign count_w    = tail_q - head_q;
    assign uncom_w    = tail_q - cptr_q;
    assign full_w     = (count_w == PW'(DEPTH));
    assign head_idx_w = head_q[IW-1:0];
    assign drn_fire_w = sq.drn_valid & sq.drn_ready;
    assign enq_fire_w = sq.enq_valid & ~full_w & ~sq.flush;

    assign sq.enq_ready = ~full_w;
    assign sq.count     = count_w;
    assign sq.half      = (count_w >= PW'(DEPTH / 2));
    assign sq.empty     = (count_w == '0);
    assign sq.drn_valid = (head_q != cptr_q);
    assign sq.drn_addr  = {ent_addr_q[head_idx_w], 2'b00};
    assign sq.drn_strb  = ent_strb_q[head_idx_w];
    assign sq.drn_data  = ent_data_q[head_idx_w];
    assign sq.drn_cache = ent_cache_q[head_idx_w];
    assign sq.drn_id    = ent_id_q[head_idx_w];

    // Commit count saturates at tail so cptr can never pass the newest entry.
    always_comb begin
        pop_w = '0;
        for (int k = 0; k < COMMIT_W; k++) begin
            pop_w = pop_w + PW'(sq.com[k]);
        end
        commit_n_w = (pop_w > uncom_w) ? uncom_w : pop_w;
    end

    always_comb begin
        head_d = head_q + PW'(drn_fire_w);
        cptr_d = cptr_q + commit_n_w;
        tail_d = tail_q;
        if (sq.flush) begin
            tail_d = cptr_d;
        end else if (enq_fire_w) begin
            tail_d = tail_q + PW'(1);
        end
    end

    always_comb begin
        enq_strb_w = 4'hF;
        enq_lane_w = sq.enq_data;
        case (sq.enq_size)
            2'd0: begin
                enq_strb_w = 4'b0001 << sq.enq_addr[1:0];
                enq_lane_w = {4{sq.enq_data[7:0]}};
            end
            2'd1: begin
                enq_strb_w = 4'b0011 << {sq.enq_addr[1], 1'b0};
                enq_lane_w = {2{sq.enq_data[15:0]}};
            end
            default: begin
                enq_strb_w = 4'hF;
                enq_lane_w = sq.enq_data;
            end
        endcase
    end

    // Walk oldest to youngest so the youngest matching store wins each lane.
    always_comb begin
        fwd_mask_w = '0;
        fwd_data_w = '0;
        fwd_hit_w  = 1'b0;
        fwd_unc_w  = 1'b0;
        fwd_idx_w  = '0;
        for (int i = 0; i < DEPTH; i++) begin
            fwd_idx_w = head_idx_w + IW'(i);
            if ((PW'(i) < count_w) &&
                (ent_addr_q[fwd_idx_w] == sq.ld_addr[31:2]) &&
                ((ent_strb_q[fwd_idx_w] & sq.ld_strb) != 4'b0000)) begin
                fwd_hit_w = 1'b1;
                if (!ent_cache_q[fwd_idx_w]) begin
                    fwd_unc_w = 1'b1;
                end
                for (int b = 0; b < 4; b++) begin
                    if (ent_strb_q[fwd_idx_w][b] & sq.ld_strb[b]) begin
                        fwd_mask_w[b]        = 1'b1;
                        fwd_data_w[8*b +: 8] = ent_data_q[fwd_idx_w][8*b +: 8];
                    end
                end
            end
        end
    end

    assign sq.fwd_mask  = fwd_mask_w;
    assign sq.fwd_data  = fwd_data_w;
    assign sq.fwd_stall = fwd_unc_w | (fwd_hit_w & ((fwd_mask_w & sq.ld_strb) != sq.ld_strb));

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            head_q <= '0;
            cptr_q <= '0;
            tail_q <= '0;
        end else begin
            head_q <= head_d;
            cptr_q <= cptr_d;
            tail_q <= tail_d;
        end
    end

    always_ff @(posedge clk) begin
        if (enq_fire_w) begin
            ent_id_q[tail_q[IW-1:0]]    <= sq.enq_id;
            ent_addr_q[tail_q[IW-1:0]]  <= sq.enq_addr[31:2];
            ent_strb_q[tail_q[IW-1:0]]  <= enq_strb_w;
            ent_data_q[tail_q[IW-1:0]]  <= enq_lane_w;
            ent_cache_q[tail_q[IW-1:0]] <= sq.enq_cache;
        end
    end

    always_ff @(posedge clk) begin
        if (resetn) begin
            assert (pop_w <= uncom_w);
        end
    end
endmodule

// File: tb/tb_store_queue.sv
// tb/tb_store_queue.sv - directed self-checking bench for store_queue
module tb_store_queue;
    logic clk = 1'b0;
    logic resetn = 1'b0;
    int   checks = 0;
    int   fails = 0;

    store_queue_if #(.DEPTH(8), .COMMIT_W(2), .ID_W(6)) sq ();

    store_queue #(.DEPTH(8), .COMMIT_W(2), .ID_W(6)) dut (
        .clk    (clk),
        .resetn (resetn),
        .sq     (sq.slave)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic enq(input logic [31:0] a, input logic [1:0] sz, input logic [31:0] d,
                       input logic c, input logic [5:0] id);
        sq.enq_valid = 1'b1;
        sq.enq_addr  = a;
        sq.enq_size  = sz;
        sq.enq_data  = d;
        sq.enq_cache = c;
        sq.enq_id    = id;
        tick();
        sq.enq_valid = 1'b0;
    endtask

    initial begin
        logic [31:0] base;
        sq.enq_valid = 1'b0; sq.enq_id = '0; sq.enq_addr = '0; sq.enq_size = '0;
        sq.enq_data = '0; sq.enq_cache = 1'b0; sq.com = '0; sq.flush = 1'b0;
        sq.drn_ready = 1'b0; sq.ld_addr = '0; sq.ld_strb = '0;
        tick(); tick();
        resetn = 1'b1;
        tick();

        check("rst_count", 32'(sq.count), 32'd0);
        check("rst_empty", 32'(sq.empty), 32'd1);
        check("rst_half", 32'(sq.half), 32'd0);
        check("rst_enq_ready", 32'(sq.enq_ready), 32'd1);
        check("rst_drn_valid", 32'(sq.drn_valid), 32'd0);
        check("rst_fwd_mask", 32'(sq.fwd_mask), 32'd0);
        check("rst_fwd_stall", 32'(sq.fwd_stall), 32'd0);

        // SB then commit: drainable next cycle
        enq(32'h100, 2'd0, 32'hAB, 1'b1, 6'd1);
        check("sb_not_yet_valid", 32'(sq.drn_valid), 32'd0);
        sq.com = 2'b01; tick(); sq.com = 2'b00;
        check("sb_drn_valid", 32'(sq.drn_valid), 32'd1);
        check("sb_drn_addr", sq.drn_addr, 32'h100);
        check("sb_drn_strb", 32'(sq.drn_strb), 32'h1);
        check("sb_drn_data", sq.drn_data, 32'hABABABAB);
        check("sb_drn_id", 32'(sq.drn_id), 32'd1);
        sq.drn_ready = 1'b1; tick(); sq.drn_ready = 1'b0;
        check("sb_drained_empty", 32'(sq.empty), 32'd1);

        // Fill / commit / drain, three laps across the pointer wrap
        for (int lap = 0; lap < 3; lap++) begin
            base = 32'h1000 + 32'(lap) * 32'h40;
            for (int k = 0; k < 8; k++) enq(base + 32'(k) * 4, 2'd2, 32'(k), 1'b1, 6'(k));
            check("full_count", 32'(sq.count), 32'd8);
            check("full_enq_ready", 32'(sq.enq_ready), 32'd0);
            check("full_half", 32'(sq.half), 32'd1);
            sq.com = 2'b11; sq.enq_valid = 1'b1; sq.enq_addr = 32'hDEAD0000; tick();
            sq.com = 2'b00;
            check("full_refuse_count", 32'(sq.count), 32'd8);
            sq.drn_ready = 1'b1;
            check("lap_drn0_addr", sq.drn_addr, base);
            tick();
            check("no_bypass_count", 32'(sq.count), 32'd7);
            sq.enq_valid = 1'b0;
            check("lap_drn1_addr", sq.drn_addr, base + 32'd4);
            tick(); sq.drn_ready = 1'b0;
            check("lap_count6", 32'(sq.count), 32'd6);
            check("lap_enq_ready", 32'(sq.enq_ready), 32'd1);
            sq.com = 2'b11; tick(); tick(); tick(); sq.com = 2'b00;
            sq.drn_ready = 1'b1;
            for (int k = 2; k < 8; k++) begin
                check("lap_drn_addr", sq.drn_addr, base + 32'(k) * 4);
                check("lap_drn_data", sq.drn_data, 32'(k));
                tick();
            end
            sq.drn_ready = 1'b0;
            check("lap_empty", 32'(sq.empty), 32'd1);
        end

        // Flush with same-cycle commit; enqueue during flush is suppressed
        for (int k = 0; k < 4; k++) enq(32'h400 + 32'(k) * 4, 2'd2, 32'(k), 1'b1, 6'(k));
        sq.com = 2'b01; tick();
        sq.flush = 1'b1; sq.enq_valid = 1'b1; sq.enq_addr = 32'h480; tick();
        sq.flush = 1'b0; sq.enq_valid = 1'b0; sq.com = 2'b00;
        check("flush_count", 32'(sq.count), 32'd2);
        sq.drn_ready = 1'b1;
        check("flush_drn0_valid", 32'(sq.drn_valid), 32'd1);
        check("flush_drn0_addr", sq.drn_addr, 32'h400);
        tick();
        check("flush_drn1_valid", 32'(sq.drn_valid), 32'd1);
        check("flush_drn1_addr", sq.drn_addr, 32'h404);
        tick();
        check("flush_drn2_valid", 32'(sq.drn_valid), 32'd0);
        check("flush_empty", 32'(sq.empty), 32'd1);
        sq.drn_ready = 1'b0;

        // Youngest-wins byte forwarding
        enq(32'h200, 2'd2, 32'h11223344, 1'b1, 6'd2);
        enq(32'h201, 2'd0, 32'hFF, 1'b1, 6'd3);
        sq.ld_addr = 32'h200; sq.ld_strb = 4'hF; #1;
        check("fwd_mask_full", 32'(sq.fwd_mask), 32'hF);
        check("fwd_data_merge", sq.fwd_data, 32'h1122FF44);
        check("fwd_stall_none", 32'(sq.fwd_stall), 32'd0);
        sq.ld_strb = 4'b0100; #1;
        check("fwd_lane2_mask", 32'(sq.fwd_mask), 32'h4);
        check("fwd_lane2_data", sq.fwd_data, 32'h00220000);
        sq.ld_addr = 32'h204; sq.ld_strb = 4'hF; #1;
        check("fwd_miss_mask", 32'(sq.fwd_mask), 32'h0);
        check("fwd_miss_stall", 32'(sq.fwd_stall), 32'd0);
        sq.flush = 1'b1; tick(); sq.flush = 1'b0;
        check("flush_nocommit_empty", 32'(sq.empty), 32'd1);

        // Partial overlap and uncached stalls
        enq(32'h300, 2'd1, 32'hBEEF, 1'b1, 6'd4);
        sq.ld_addr = 32'h300; sq.ld_strb = 4'hF; #1;
        check("partial_mask", 32'(sq.fwd_mask), 32'h3);
        check("partial_stall", 32'(sq.fwd_stall), 32'd1);
        sq.flush = 1'b1; tick(); sq.flush = 1'b0;
        enq(32'hA000_0000, 2'd2, 32'h5555AAAA, 1'b0, 6'd5);
        sq.ld_addr = 32'hA000_0000; sq.ld_strb = 4'hF; #1;
        check("uncached_stall", 32'(sq.fwd_stall), 32'd1);
        sq.flush = 1'b1; tick(); sq.flush = 1'b0;
        sq.ld_strb = 4'h0;

        // Back-pressured head holds stable, then asynchronous reset
        enq(32'h500, 2'd2, 32'hCAFEF00D, 1'b1, 6'd6);
        sq.com = 2'b01; tick(); sq.com = 2'b00;
        for (int k = 0; k < 5; k++) begin
            check("hold_drn_valid", 32'(sq.drn_valid), 32'd1);
            check("hold_drn_addr", sq.drn_addr, 32'h500);
            check("hold_drn_data", sq.drn_data, 32'hCAFEF00D);
            check("hold_count", 32'(sq.count), 32'd1);
            tick();
        end
        enq(32'h504, 2'd2, 32'h1, 1'b1, 6'd7);
        @(posedge clk); #3;
        resetn = 1'b0; #1;
        check("async_rst_empty", 32'(sq.empty), 32'd1);
        check("async_rst_drn_valid", 32'(sq.drn_valid), 32'd0);
        check("async_rst_count", 32'(sq.count), 32'd0);
        check("async_rst_enq_ready", 32'(sq.enq_ready), 32'd1);

        $display("%0d/%0d checks passed", checks - fails, checks);
        $finish;
    end
endmodule
